stack_alu_hs: RTL and testbench
===============================

// Module: stack_alu_hs
// PURPOSE
//  Next-generation parametrised stack calculator: LIFO of WIDTH-bit signed words with in-place arithmetic.
//  Adds valid/ready command handshake, per-command response strobe, SUB/DUP/SWAP ops and iterative multiply.
//  Opcode encodings of the existing stack are kept. Sits between the command sequencer and result sink.
// PARAMETERS
//  DEPTH     256  max entries (>=2)
//  WIDTH     32   data width, two's-complement signed
//  MUL_STEP  1    multiplier bits retired per cycle; must divide WIDTH
// PORTS
//  clk          in   1                  clock, rising edge
//  rst_n        in   1                  asynchronous active-low reset
//  cmd_valid    in   1                  command present
//  cmd_ready    out  1                  block can accept a command
//  opcode       in   3                  000 NOP,001 DUP,010 SWAP,011 SUB,100 ADD,101 MUL,110 PUSH,111 POP
//  input_data   in   WIDTH              PUSH operand
//  rsp_valid    out  1                  1-cycle pulse, one per accepted command
//  output_data  out  WIDTH              result / popped value
//  error        out  1                  accepted command was illegal (qualified by rsp_valid)
//  overflow     out  1                  signed arithmetic overflow (qualified by rsp_valid)
//  empty        out  1                  count==0
//  full         out  1                  count==DEPTH
//  count        out  $clog2(DEPTH+1)    current occupancy
// BEHAVIOUR
//  Reset: count=0, output_data=0, rsp_valid=0, error=0, overflow=0, empty=1, full=0, cmd_ready=1, FSM=IDLE.
//  Reset mid-MUL aborts: operands discarded, no rsp_valid.
//  Accept = cmd_valid & cmd_ready in cycle N. Exactly one rsp_valid pulse per accept.
//  FSM IDLE: cmd_ready=1. Non-MUL op completes at edge ending N; rsp_valid=1 in N+1.
//  Back-to-back single-cycle accepts are sustained every cycle.
//  Legal MUL: IDLE->MUL_BUSY at edge ending N; cmd_ready=0 from N+1.
//  MUL_BUSY runs K=WIDTH/MUL_STEP cycles, then returns to IDLE; rsp_valid=1 and cmd_ready=1 in cycle N+1+K.
//  Operands: T=top, S=next. Arithmetic writes result as new top, count-1.
//  ADD S+T, SUB S-T, MUL S*T. Result truncated to WIDTH bits.
//  overflow=1 when true signed result is not representable in WIDTH bits; includes MUL of -2^(W-1) * -1.
//  PUSH: mem[count]=input_data, count+1, output_data=input_data.
//  POP: output_data=T, count-1.
//  DUP: push copy of T, output_data=T.
//  SWAP: exchange T and S, output_data=new top.
//  NOP: nothing changes except rsp_valid pulse.
//  Arithmetic ops: output_data=result.
//  Illegal -> error=1 with rsp_valid, stack/count/output_data unchanged, overflow=0, MUL does not enter MUL_BUSY:
//    PUSH when full; POP when empty; DUP when empty or full; SWAP/ADD/SUB/MUL when count<2.
//  error/overflow are per-command, not sticky. They hold their value until the next rsp_valid.
//  empty/full/count update at the same edge as the stack; during MUL_BUSY they show pre-MUL state.
//  MUL updates them at completion.
//  cmd_valid ignored while cmd_ready=0; opcode/input_data sampled only on accept.
// STRUCTURE
//  Package stack_alu_pkg: opcode_e enum (values above), state_e {IDLE, MUL_BUSY}, helper function for count width.
//  Storage: flop array DEPTH x WIDTH with two read taps (count-1, count-2). No reset on array contents.
//  Sub-module stack_seq_mul: signed iterative multiplier.
//    Interface: start, a, b -> done, product[WIDTH-1:0], ovf.
//    Shift-add over magnitudes, MUL_STEP bits/cycle, sign fixed at end. done pulses in cycle K after start.
// TESTING (DEPTH=4 unless noted)
//  1 Reset then PUSH 1..4 -> count=4, full=1. PUSH 5 -> error=1, count=4, output_data=4. POP x4 -> 4,3,2,1, empty=1.
//    POP -> error=1.
//  2 PUSH 10, PUSH 20, ADD -> output_data=30, count=1. PUSH 5, SUB -> 25. NOP -> rsp_valid, output_data=25.
//  3 PUSH 0x7FFFFFFF, PUSH 1, ADD -> output_data=0x80000000, overflow=1. PUSH 0xFFFFFFFF, PUSH 2, ADD -> 1, overflow=0.
//  4 PUSH -6, PUSH 7, MUL (MUL_STEP=1) -> cmd_ready low 32 cycles, cmd_valid held high ignored.
//    rsp_valid at N+33, output_data=-42, overflow=0.
//    Repeat with 0x10000 * 0x10000 -> 0, overflow=1. Repeat with MUL_STEP=4 -> rsp at N+9.
//  5 PUSH 3, DUP, SWAP with count=2 -> top 3, count=2. ADD with count=1 -> error=1, stack intact.
//    DUP when full -> error=1.
//  6 Start MUL, assert rst_n=0 at cycle N+5 -> no rsp_valid; count=0, empty=1, cmd_ready=1 after release.
//    Also check random op mix vs. reference model, 1 rsp_valid per accept.

Source files
------------

// File: rtl/stack_alu_hs_pkg.sv
// stack_alu_pkg: opcodes, FSM states and count-width helper shared by the stack ALU files
package stack_alu_pkg;
  typedef enum logic [2:0] {
    OP_NOP = 3'b000, OP_DUP, OP_SWAP, OP_SUB, OP_ADD, OP_MUL, OP_PUSH, OP_POP
  } opcode_e;
  typedef enum logic {IDLE, MUL_BUSY} state_e;
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/stack_alu_hs_if.sv
// stack_alu_hs_if: command/response bundle; master drives cmd_valid/opcode/input_data, slave drives the rest
interface stack_alu_hs_if import stack_alu_pkg::*; #(parameter int DEPTH = 256, parameter int WIDTH = 32);
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [2:0]                opcode;
  logic [WIDTH-1:0]          input_data;
  logic                      rsp_valid;
  logic [WIDTH-1:0]          output_data;
  logic                      error;
  logic                      overflow;
  logic                      empty;
  logic                      full;
  logic [cnt_w(DEPTH)-1:0]   count;
  modport master (output cmd_valid, opcode, input_data,
                  input cmd_ready, rsp_valid, output_data, error, overflow, empty, full, count);
  modport slave (input cmd_valid, opcode, input_data,
                 output cmd_ready, rsp_valid, output_data, error, overflow, empty, full, count);
endinterface

// File: rtl/stack_alu_hs_mul.sv
// stack_seq_mul: signed shift-add multiplier over magnitudes, MUL_STEP bits/cycle, done in cycle K after start
// ports: start,a,b in; done (combinational, final cycle), product (low WIDTH bits), ovf (signed overflow)
module stack_seq_mul #(parameter int WIDTH = 32, parameter int MUL_STEP = 1) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic             ovf
);
  localparam int K = WIDTH / MUL_STEP;
  localparam int KW = $clog2(K + 1);
  localparam int W2 = 2 * WIDTH;
  logic busy, neg;
  logic [KW-1:0] k;
  logic [W2-1:0] mc, p, p_nx, res;
  logic [WIDTH-1:0] mb, ma_in, mb_in;
  assign ma_in = a[WIDTH-1] ? -a : a;
  assign mb_in = b[WIDTH-1] ? -b : b;
  // the last step is folded in combinationally so the result is ready in the done cycle
  assign p_nx = p + mc * W2'(mb[MUL_STEP-1:0]);
  assign res = neg ? -p_nx : p_nx;
  assign done = busy && k == KW'(K - 1);
  assign product = res[WIDTH-1:0];
  assign ovf = res[W2-1:WIDTH-1] != '0 && res[W2-1:WIDTH-1] != '1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      busy <= 1'b0;
      k <= '0;
    end else begin
      busy <= start ? 1'b1 : done ? 1'b0 : busy;
      k <= start ? '0 : busy ? k + KW'(1) : k;
    end
  always_ff @(posedge clk)
    if (start) begin
      mc <= {{WIDTH{1'b0}}, ma_in};
      mb <= mb_in;
      neg <= a[WIDTH-1] ^ b[WIDTH-1];
      p <= '0;
    end else if (busy) begin
      p <= p_nx;
      mc <= mc << MUL_STEP;
      mb <= mb >> MUL_STEP;
    end
endmodule

// File: rtl/stack_alu_hs.sv
// stack_alu_hs: LIFO of signed words with in-place arithmetic behind a valid/ready command handshake
// ports: clk, rst_n (async active-low), bus (slave side of stack_alu_hs_if)
module stack_alu_hs import stack_alu_pkg::*; #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 32,
  parameter int MUL_STEP = 1
) (
  input logic clk,
  input logic rst_n,
  stack_alu_hs_if.slave bus
);
  localparam int CW = cnt_w(DEPTH);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  state_e state, state_d;
  opcode_e op;
  logic [CW-1:0] cnt, cnt_d;
  logic [AW-1:0] ia_p, ia_t, ia_s, wa;
  logic [WIDTH-1:0] t, s, sum, dif, mprod, wd, out_d;
  logic acc, ill, we, sw, mstart, mdone, mdone_now, movf, ovf_d, rsp_d;
  assign op = opcode_e'(bus.opcode);
  assign ia_p = AW'(cnt);
  assign ia_t = AW'(cnt - CW'(1));
  assign ia_s = AW'(cnt - CW'(2));
  assign t = mem[ia_t];
  assign s = mem[ia_s];
  assign sum = s + t;
  assign dif = s - t;
  assign bus.cmd_ready = state == IDLE;
  assign bus.empty = cnt == '0;
  assign bus.full = cnt == CW'(DEPTH);
  assign bus.count = cnt;
  assign acc = bus.cmd_valid && bus.cmd_ready;
  assign ill = op == OP_NOP ? 1'b0 : op == OP_PUSH ? bus.full : op == OP_POP ? bus.empty :
               op == OP_DUP ? (bus.empty || bus.full) : cnt < CW'(2);
  assign mstart = acc && op == OP_MUL && !ill;
  assign mdone_now = state == MUL_BUSY && mdone;
  // a legal MUL answers only when the multiplier finishes
  assign rsp_d = (acc && (ill || op != OP_MUL)) || mdone_now;
  assign state_d = state == IDLE ? (mstart ? MUL_BUSY : IDLE) : (mdone ? IDLE : MUL_BUSY);
  stack_seq_mul #(.WIDTH(WIDTH), .MUL_STEP(MUL_STEP)) u_mul (
    .clk(clk), .rst_n(rst_n), .start(mstart), .a(s), .b(t),
    .done(mdone), .product(mprod), .ovf(movf)
  );
  always_comb begin
    cnt_d = cnt;
    out_d = bus.output_data;
    ovf_d = 1'b0;
    we = 1'b0;
    wa = ia_s;
    wd = t;
    sw = 1'b0;
    if (mdone_now) begin
      cnt_d = cnt - CW'(1);
      out_d = mprod;
      ovf_d = movf;
      we = 1'b1;
      wd = mprod;
    end else if (acc && !ill) begin
      case (op)
        OP_PUSH: begin cnt_d = cnt + CW'(1); out_d = bus.input_data; we = 1'b1; wa = ia_p; wd = bus.input_data; end
        OP_POP:  begin cnt_d = cnt - CW'(1); out_d = t; end
        OP_DUP:  begin cnt_d = cnt + CW'(1); out_d = t; we = 1'b1; wa = ia_p; end
        OP_SWAP: begin out_d = s; we = 1'b1; sw = 1'b1; end
        OP_ADD:  begin
          cnt_d = cnt - CW'(1); out_d = sum; we = 1'b1; wd = sum;
          ovf_d = s[WIDTH-1] == t[WIDTH-1] && sum[WIDTH-1] != s[WIDTH-1];
        end
        OP_SUB:  begin
          cnt_d = cnt - CW'(1); out_d = dif; we = 1'b1; wd = dif;
          ovf_d = s[WIDTH-1] != t[WIDTH-1] && dif[WIDTH-1] != s[WIDTH-1];
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      bus.output_data <= '0;
      bus.rsp_valid <= 1'b0;
      bus.error <= 1'b0;
      bus.overflow <= 1'b0;
    end else begin
      cnt <= cnt_d;
      bus.output_data <= out_d;
      bus.rsp_valid <= rsp_d;
      if (rsp_d) begin
        bus.error <= acc && ill;
        bus.overflow <= ovf_d;
      end
    end
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    if (sw) mem[ia_t] <= s;
  end
endmodule

// File: tb/tb_stack_alu_hs.sv
// tb_stack_alu_hs: directed and model-checked bench for stack_alu_hs (DEPTH=4, MUL_STEP=1 and 4)
module tb_stack_alu_hs;
  import stack_alu_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0, checks = 0, lat, lo, rsp_n = 0, acc_n = 0;
  stack_alu_hs_if #(.DEPTH(4), .WIDTH(32)) bus0();
  stack_alu_hs_if #(.DEPTH(4), .WIDTH(32)) bus4();
  stack_alu_hs #(.DEPTH(4), .WIDTH(32), .MUL_STEP(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  stack_alu_hs #(.DEPTH(4), .WIDTH(32), .MUL_STEP(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (bus0.rsp_valid) rsp_n++;
    if (bus0.cmd_valid && bus0.cmd_ready) acc_n++;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cmd(input bit u, input logic [2:0] op, input logic [31:0] d);
    if (u) begin bus4.cmd_valid = 1'b1; bus4.opcode = op; bus4.input_data = d; end
    else begin bus0.cmd_valid = 1'b1; bus0.opcode = op; bus0.input_data = d; end
    @(posedge clk); #1;
    bus0.cmd_valid = 1'b0;
    bus4.cmd_valid = 1'b0;
    lat = 1;
    while (!(u ? bus4.rsp_valid : bus0.rsp_valid) && lat < 100) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic test_reset;
    checks++; if ({bus0.count, bus0.empty, bus0.full, bus0.cmd_ready} !== {3'd0, 1'b1, 1'b0, 1'b1}) begin errors++; $display("FAIL reset_status got cnt=%0d e=%b f=%b rdy=%b exp 0 1 0 1", bus0.count, bus0.empty, bus0.full, bus0.cmd_ready); end
    checks++; if ({bus0.rsp_valid, bus0.error, bus0.overflow, bus0.output_data} !== {3'b000, 32'd0}) begin errors++; $display("FAIL reset_outputs got rsp=%b err=%b ovf=%b out=%h exp 0 0 0 0", bus0.rsp_valid, bus0.error, bus0.overflow, bus0.output_data); end
  endtask

  task automatic test_push_pop;
    for (int i = 1; i <= 4; i++) cmd(0, OP_PUSH, 32'(i));
    checks++; if ({bus0.count, bus0.full, bus0.output_data} !== {3'd4, 1'b1, 32'd4}) begin errors++; $display("FAIL fill got cnt=%0d full=%b out=%h exp 4 1 4", bus0.count, bus0.full, bus0.output_data); end
    cmd(0, OP_PUSH, 32'd5);
    checks++; if ({lat, bus0.error, bus0.count, bus0.output_data} !== {32'd1, 1'b1, 3'd4, 32'd4}) begin errors++; $display("FAIL push_full got lat=%0d err=%b cnt=%0d out=%h exp 1 1 4 4", lat, bus0.error, bus0.count, bus0.output_data); end
    for (int i = 4; i >= 1; i--) begin
      cmd(0, OP_POP, 32'd0);
      checks++; if ({bus0.error, bus0.output_data, bus0.count} !== {1'b0, 32'(i), 3'(i - 1)}) begin errors++; $display("FAIL pop_%0d got err=%b out=%h cnt=%0d exp 0 %h %0d", i, bus0.error, bus0.output_data, bus0.count, i, i - 1); end
    end
    checks++; if (bus0.empty !== 1'b1) begin errors++; $display("FAIL drained_empty got %b exp 1", bus0.empty); end
    cmd(0, OP_POP, 32'd0);
    checks++; if ({bus0.error, bus0.count, bus0.output_data} !== {1'b1, 3'd0, 32'd1}) begin errors++; $display("FAIL pop_empty got err=%b cnt=%0d out=%h exp 1 0 1", bus0.error, bus0.count, bus0.output_data); end
  endtask

  task automatic test_arith;
    cmd(0, OP_PUSH, 32'd10); cmd(0, OP_PUSH, 32'd20); cmd(0, OP_ADD, 32'd0);
    checks++; if ({bus0.error, bus0.overflow, bus0.output_data, bus0.count} !== {2'b00, 32'd30, 3'd1}) begin errors++; $display("FAIL add got err=%b ovf=%b out=%h cnt=%0d exp 0 0 1e 1", bus0.error, bus0.overflow, bus0.output_data, bus0.count); end
    cmd(0, OP_PUSH, 32'd5); cmd(0, OP_SUB, 32'd0);
    checks++; if ({bus0.output_data, bus0.count} !== {32'd25, 3'd1}) begin errors++; $display("FAIL sub got out=%h cnt=%0d exp 19 1", bus0.output_data, bus0.count); end
    cmd(0, OP_NOP, 32'hDEAD);
    checks++; if ({lat, bus0.error, bus0.output_data, bus0.count} !== {32'd1, 1'b0, 32'd25, 3'd1}) begin errors++; $display("FAIL nop got lat=%0d err=%b out=%h cnt=%0d exp 1 0 19 1", lat, bus0.error, bus0.output_data, bus0.count); end
    cmd(0, OP_POP, 32'd0);
    cmd(0, OP_PUSH, 32'h7FFFFFFF); cmd(0, OP_PUSH, 32'd1); cmd(0, OP_ADD, 32'd0);
    checks++; if ({bus0.overflow, bus0.output_data} !== {1'b1, 32'h80000000}) begin errors++; $display("FAIL add_ovf got ovf=%b out=%h exp 1 80000000", bus0.overflow, bus0.output_data); end
    cmd(0, OP_POP, 32'd0);
    cmd(0, OP_PUSH, 32'hFFFFFFFF); cmd(0, OP_PUSH, 32'd2); cmd(0, OP_ADD, 32'd0);
    checks++; if ({bus0.overflow, bus0.output_data} !== {1'b0, 32'd1}) begin errors++; $display("FAIL add_wrap got ovf=%b out=%h exp 0 1", bus0.overflow, bus0.output_data); end
    cmd(0, OP_POP, 32'd0);
    cmd(0, OP_PUSH, 32'h80000000); cmd(0, OP_PUSH, 32'd1); cmd(0, OP_SUB, 32'd0);
    checks++; if ({bus0.overflow, bus0.output_data} !== {1'b1, 32'h7FFFFFFF}) begin errors++; $display("FAIL sub_ovf got ovf=%b out=%h exp 1 7fffffff", bus0.overflow, bus0.output_data); end
    cmd(0, OP_POP, 32'd0);
  endtask

  task automatic test_mul;
    cmd(0, OP_PUSH, 32'hFFFFFFFA); cmd(0, OP_PUSH, 32'd7);
    bus0.cmd_valid = 1'b1; bus0.opcode = OP_MUL;
    @(posedge clk); #1;
    bus0.opcode = OP_PUSH; bus0.input_data = 32'd99;
    checks++; if ({bus0.cmd_ready, bus0.count} !== {1'b0, 3'd2}) begin errors++; $display("FAIL mul_busy got rdy=%b cnt=%0d exp 0 2", bus0.cmd_ready, bus0.count); end
    lo = 0; lat = 1;
    while (!bus0.rsp_valid && lat < 100) begin if (!bus0.cmd_ready) lo++; @(posedge clk); #1; lat++; end
    bus0.cmd_valid = 1'b0;
    checks++; if ({lat, lo} !== {32'd33, 32'd32}) begin errors++; $display("FAIL mul_latency got lat=%0d low=%0d exp 33 32", lat, lo); end
    checks++; if ({bus0.output_data, bus0.overflow, bus0.error, bus0.count, bus0.cmd_ready} !== {32'hFFFFFFD6, 2'b00, 3'd1, 1'b1}) begin errors++; $display("FAIL mul_neg got out=%h ovf=%b err=%b cnt=%0d rdy=%b exp ffffffd6 0 0 1 1", bus0.output_data, bus0.overflow, bus0.error, bus0.count, bus0.cmd_ready); end
    @(posedge clk); #1;
    checks++; if ({bus0.rsp_valid, bus0.count} !== {1'b0, 3'd1}) begin errors++; $display("FAIL mul_pulse got rsp=%b cnt=%0d exp 0 1", bus0.rsp_valid, bus0.count); end
    cmd(0, OP_POP, 32'd0);
    cmd(0, OP_PUSH, 32'h10000); cmd(0, OP_PUSH, 32'h10000); cmd(0, OP_MUL, 32'd0);
    checks++; if ({lat, bus0.output_data, bus0.overflow} !== {32'd33, 32'd0, 1'b1}) begin errors++; $display("FAIL mul_big got lat=%0d out=%h ovf=%b exp 33 0 1", lat, bus0.output_data, bus0.overflow); end
    cmd(0, OP_POP, 32'd0);
    cmd(0, OP_PUSH, 32'h80000000); cmd(0, OP_PUSH, 32'hFFFFFFFF); cmd(0, OP_MUL, 32'd0);
    checks++; if ({bus0.output_data, bus0.overflow} !== {32'h80000000, 1'b1}) begin errors++; $display("FAIL mul_minneg got out=%h ovf=%b exp 80000000 1", bus0.output_data, bus0.overflow); end
    cmd(0, OP_POP, 32'd0);
    cmd(0, OP_PUSH, 32'h80000000); cmd(0, OP_PUSH, 32'd1); cmd(0, OP_MUL, 32'd0);
    checks++; if ({bus0.output_data, bus0.overflow} !== {32'h80000000, 1'b0}) begin errors++; $display("FAIL mul_min_one got out=%h ovf=%b exp 80000000 0", bus0.output_data, bus0.overflow); end
    cmd(0, OP_POP, 32'd0);
    cmd(0, OP_PUSH, 32'd3); cmd(0, OP_MUL, 32'd0);
    checks++; if ({lat, bus0.error, bus0.count, bus0.cmd_ready} !== {32'd1, 1'b1, 3'd1, 1'b1}) begin errors++; $display("FAIL mul_short got lat=%0d err=%b cnt=%0d rdy=%b exp 1 1 1 1", lat, bus0.error, bus0.count, bus0.cmd_ready); end
    cmd(0, OP_POP, 32'd0);
    cmd(1, OP_PUSH, 32'hFFFFFFFD); cmd(1, OP_PUSH, 32'd17); cmd(1, OP_MUL, 32'd0);
    checks++; if ({lat, bus4.output_data, bus4.overflow, bus4.count} !== {32'd9, 32'hFFFFFFCD, 1'b0, 3'd1}) begin errors++; $display("FAIL mul_step4 got lat=%0d out=%h ovf=%b cnt=%0d exp 9 ffffffcd 0 1", lat, bus4.output_data, bus4.overflow, bus4.count); end
  endtask

  task automatic test_stack_ops;
    cmd(0, OP_DUP, 32'd0);
    checks++; if ({bus0.error, bus0.count} !== {1'b1, 3'd0}) begin errors++; $display("FAIL dup_empty got err=%b cnt=%0d exp 1 0", bus0.error, bus0.count); end
    cmd(0, OP_PUSH, 32'd3); cmd(0, OP_DUP, 32'd0); cmd(0, OP_SWAP, 32'd0);
    checks++; if ({bus0.error, bus0.output_data, bus0.count} !== {1'b0, 32'd3, 3'd2}) begin errors++; $display("FAIL dup_swap got err=%b out=%h cnt=%0d exp 0 3 2", bus0.error, bus0.output_data, bus0.count); end
    cmd(0, OP_POP, 32'd0); cmd(0, OP_POP, 32'd0);
    cmd(0, OP_PUSH, 32'd9); cmd(0, OP_ADD, 32'd0);
    checks++; if ({bus0.error, bus0.overflow, bus0.count, bus0.output_data} !== {2'b10, 3'd1, 32'd9}) begin errors++; $display("FAIL add_short got err=%b ovf=%b cnt=%0d out=%h exp 1 0 1 9", bus0.error, bus0.overflow, bus0.count, bus0.output_data); end
    cmd(0, OP_PUSH, 32'd2); cmd(0, OP_SWAP, 32'd0);
    checks++; if (bus0.output_data !== 32'd9) begin errors++; $display("FAIL swap_top got %h exp 9", bus0.output_data); end
    cmd(0, OP_POP, 32'd0); cmd(0, OP_POP, 32'd0);
    checks++; if ({bus0.output_data, bus0.count} !== {32'd2, 3'd0}) begin errors++; $display("FAIL swap_next got out=%h cnt=%0d exp 2 0", bus0.output_data, bus0.count); end
    for (int i = 0; i < 4; i++) cmd(0, OP_PUSH, 32'(i + 40));
    cmd(0, OP_DUP, 32'd0);
    checks++; if ({bus0.error, bus0.count, bus0.output_data} !== {1'b1, 3'd4, 32'd43}) begin errors++; $display("FAIL dup_full got err=%b cnt=%0d out=%h exp 1 4 2b", bus0.error, bus0.count, bus0.output_data); end
    for (int i = 0; i < 4; i++) cmd(0, OP_POP, 32'd0);
  endtask

  task automatic test_back_to_back;
    bus0.cmd_valid = 1'b1; bus0.opcode = OP_PUSH; bus0.input_data = 32'd11;
    @(posedge clk); #1;
    checks++; if ({bus0.rsp_valid, bus0.output_data, bus0.count} !== {1'b1, 32'd11, 3'd1}) begin errors++; $display("FAIL b2b_1 got rsp=%b out=%h cnt=%0d exp 1 b 1", bus0.rsp_valid, bus0.output_data, bus0.count); end
    bus0.input_data = 32'd22;
    @(posedge clk); #1;
    checks++; if ({bus0.rsp_valid, bus0.output_data, bus0.count} !== {1'b1, 32'd22, 3'd2}) begin errors++; $display("FAIL b2b_2 got rsp=%b out=%h cnt=%0d exp 1 16 2", bus0.rsp_valid, bus0.output_data, bus0.count); end
    bus0.opcode = OP_ADD;
    @(posedge clk); #1;
    checks++; if ({bus0.rsp_valid, bus0.output_data, bus0.count} !== {1'b1, 32'd33, 3'd1}) begin errors++; $display("FAIL b2b_3 got rsp=%b out=%h cnt=%0d exp 1 21 1", bus0.rsp_valid, bus0.output_data, bus0.count); end
    bus0.cmd_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus0.rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle got rsp=%b exp 0", bus0.rsp_valid); end
    cmd(0, OP_POP, 32'd0);
  endtask

  task automatic test_reset_mul;
    bit seen = 1'b0;
    cmd(0, OP_PUSH, 32'd2); cmd(0, OP_PUSH, 32'd3);
    bus0.cmd_valid = 1'b1; bus0.opcode = OP_MUL;
    @(posedge clk); #1;
    bus0.cmd_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    repeat (2) begin @(posedge clk); #1; if (bus0.rsp_valid) seen = 1'b1; end
    rst_n = 1'b1;
    repeat (40) begin @(posedge clk); #1; if (bus0.rsp_valid) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL reset_mul_rsp got rsp seen=%b exp 0", seen); end
    checks++; if ({bus0.count, bus0.empty, bus0.cmd_ready, bus0.output_data} !== {3'd0, 1'b1, 1'b1, 32'd0}) begin errors++; $display("FAIL reset_mul_state got cnt=%0d e=%b rdy=%b out=%h exp 0 1 1 0", bus0.count, bus0.empty, bus0.cmd_ready, bus0.output_data); end
  endtask

  task automatic test_random;
    logic [31:0] mdl [4];
    logic [31:0] mo = 32'd0, d;
    logic [2:0] op;
    int mc = 0, el, acc0, rsp0;
    bit me, mv;
    longint sv, tv, r;
    acc0 = acc_n; rsp0 = rsp_n;
    for (int n = 0; n < 80; n++) begin
      op = ($urandom_range(0, 3) == 0) ? 3'd6 : 3'($urandom_range(0, 7));
      case ($urandom_range(0, 4))
        0: d = 32'h7FFFFFFF;
        1: d = 32'h80000000;
        2: d = 32'hFFFFFFFF;
        3: d = 32'($urandom_range(0, 20));
        default: d = $urandom;
      endcase
      me = 1'b0; mv = 1'b0; el = 1;
      case (op)
        3'd0: ;
        3'd6: if (mc == 4) me = 1'b1; else begin mdl[mc] = d; mc++; mo = d; end
        3'd7: if (mc == 0) me = 1'b1; else begin mo = mdl[mc-1]; mc--; end
        3'd1: if (mc == 0 || mc == 4) me = 1'b1; else begin mo = mdl[mc-1]; mdl[mc] = mo; mc++; end
        3'd2: if (mc < 2) me = 1'b1; else begin mo = mdl[mc-2]; mdl[mc-2] = mdl[mc-1]; mdl[mc-1] = mo; end
        default: if (mc < 2) me = 1'b1; else begin
          sv = longint'(signed'(mdl[mc-2]));
          tv = longint'(signed'(mdl[mc-1]));
          r = op == 3'd4 ? sv + tv : op == 3'd3 ? sv - tv : sv * tv;
          mv = r > 64'sd2147483647 || r < -64'sd2147483648;
          mo = r[31:0];
          mdl[mc-2] = mo;
          mc--;
          el = op == 3'd5 ? 33 : 1;
        end
      endcase
      cmd(0, op, d);
      checks++; if ({lat, bus0.output_data, bus0.error, bus0.overflow, bus0.count} !== {el, mo, me, mv, 3'(mc)}) begin errors++; $display("FAIL random_%0d op=%0d got lat=%0d out=%h err=%b ovf=%b cnt=%0d exp %0d %h %b %b %0d", n, op, lat, bus0.output_data, bus0.error, bus0.overflow, bus0.count, el, mo, me, mv, mc); end
    end
    @(negedge clk); #1;
    checks++; if (rsp_n - rsp0 !== acc_n - acc0) begin errors++; $display("FAIL rsp_per_accept got rsp=%0d exp %0d", rsp_n - rsp0, acc_n - acc0); end
  endtask

  initial begin
    bus0.cmd_valid = 1'b0; bus0.opcode = 3'd0; bus0.input_data = 32'd0;
    bus4.cmd_valid = 1'b0; bus4.opcode = 3'd0; bus4.input_data = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset;
    test_push_pop;
    test_arith;
    test_mul;
    test_stack_ops;
    test_back_to_back;
    test_reset_mul;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
